// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port 16-bit memory arbiter for fetch and data stages
//
// Purpose: serves 32-bit instruction fetches as two 16-bit bus transfers and
// 16-bit data accesses as one transfer. Data has priority over fetch. Every
// transfer is bounded by a TIMEOUT-cycle ack timeout.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   ram_read_i, ram_addr_i        fetch request (level) and instruction address
//   ram_cack_o, ram_data_ready_o  fetch accept / data valid pulses
//   ram_data_o, ram_busy_o        fetched instruction, arbiter busy (combinational)
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i                     data access request and command fields
//   d_cack_o, d_ready_o, d_rdata_o data accept / complete pulses, read data
//   mem_req_o, mem_we_o, mem_ispace_o, mem_addr_o, mem_wdata_o  bus command
//   mem_rdata_i, mem_ack_i        bus response
//   bus_err_o                     timeout pulse
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ram_read_i,
  input  logic [15:0] ram_addr_i,
  output logic        ram_cack_o,
  output logic        ram_data_ready_o,
  output logic [31:0] ram_data_o,
  output logic        ram_busy_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [15:0] d_addr_i,
  input  logic [15:0] d_wdata_i,
  output logic        d_cack_o,
  output logic        d_ready_o,
  output logic [15:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_ispace_o,
  output logic [16:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, I_LO, I_HI, D_ACC} state_e;

  // The counter holds the number of unacked cycles already spent in the
  // current transfer, so the TIMEOUT-th unacked cycle sees TIMEOUT-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  tmo_cnt_q;
  logic        ram_cack_q, ram_data_ready_q, d_cack_q, d_ready_q, bus_err_q;
  logic [31:0] ram_data_q;
  logic [15:0] d_rdata_q;
  logic        mem_req_q, mem_we_q, mem_ispace_q;
  logic [16:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      tmo_cnt_q        <= '0;
      ram_cack_q       <= 1'b0;
      ram_data_ready_q <= 1'b0;
      d_cack_q         <= 1'b0;
      d_ready_q        <= 1'b0;
      bus_err_q        <= 1'b0;
      ram_data_q       <= '0;
      d_rdata_q        <= '0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_ispace_q     <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
    end else begin
      ram_cack_q       <= 1'b0;
      ram_data_ready_q <= 1'b0;
      d_cack_q         <= 1'b0;
      d_ready_q        <= 1'b0;
      bus_err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_cnt_q <= '0;
          if (d_req_i) begin
            d_cack_q     <= 1'b1;
            mem_req_q    <= 1'b1;
            mem_ispace_q <= 1'b0;
            mem_we_q     <= d_we_i;
            mem_addr_q   <= {1'b0, d_addr_i};
            mem_wdata_q  <= d_wdata_i;
            state_q      <= D_ACC;
          end else if (ram_read_i) begin
            // mem_addr_q[16:1] doubles as the latched fetch address A.
            ram_cack_q   <= 1'b1;
            mem_req_q    <= 1'b1;
            mem_ispace_q <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ram_addr_i, 1'b0};
            mem_wdata_q  <= '0;
            state_q      <= I_LO;
          end
        end
        I_LO: begin
          if (mem_ack_i) begin
            ram_data_q[15:0] <= mem_rdata_i;
            mem_addr_q[0]    <= 1'b1;
            tmo_cnt_q        <= '0;
            state_q          <= I_HI;
          end else if (tmo_hit) begin
            ram_data_q       <= '0;
            ram_data_ready_q <= 1'b1;
            bus_err_q        <= 1'b1;
            mem_req_q        <= 1'b0;
            state_q          <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        I_HI: begin
          if (mem_ack_i) begin
            ram_data_q[31:16] <= mem_rdata_i;
            ram_data_ready_q  <= 1'b1;
            mem_req_q         <= 1'b0;
            tmo_cnt_q         <= '0;
            state_q           <= IDLE;
          end else if (tmo_hit) begin
            ram_data_q       <= '0;
            ram_data_ready_q <= 1'b1;
            bus_err_q        <= 1'b1;
            mem_req_q        <= 1'b0;
            state_q          <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        D_ACC: begin
          if (mem_ack_i) begin
            if (!mem_we_q) d_rdata_q <= mem_rdata_i;
            d_ready_q <= 1'b1;
            mem_req_q <= 1'b0;
            tmo_cnt_q <= '0;
            state_q   <= IDLE;
          end else if (tmo_hit) begin
            if (!mem_we_q) d_rdata_q <= '0;
            d_ready_q <= 1'b1;
            bus_err_q <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_busy_o       = (state_q != IDLE) | d_req_i;
  assign ram_cack_o       = ram_cack_q;
  assign ram_data_ready_o = ram_data_ready_q;
  assign ram_data_o       = ram_data_q;
  assign d_cack_o         = d_cack_q;
  assign d_ready_o        = d_ready_q;
  assign d_rdata_o        = d_rdata_q;
  assign mem_req_o        = mem_req_q;
  assign mem_we_o         = mem_we_q;
  assign mem_ispace_o     = mem_ispace_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_wdata_o      = mem_wdata_q;
  assign bus_err_o        = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ram_read_i;
  logic [15:0] ram_addr_i;
  logic        ram_cack_o, ram_data_ready_o, ram_busy_o;
  logic [31:0] ram_data_o;
  logic        d_req_i, d_we_i;
  logic [15:0] d_addr_i, d_wdata_i;
  logic        d_cack_o, d_ready_o;
  logic [15:0] d_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ispace_o;
  logic [16:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [15:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        bus_err_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ram_read_i(ram_read_i), .ram_addr_i(ram_addr_i),
    .ram_cack_o(ram_cack_o), .ram_data_ready_o(ram_data_ready_o),
    .ram_data_o(ram_data_o), .ram_busy_o(ram_busy_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_cack_o(d_cack_o), .d_ready_o(d_ready_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_ispace_o(mem_ispace_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .bus_err_o(bus_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: expected bus command per transfer of the current
  // transaction, slave wait plan and read data, and the architectural
  // values of ram_data / d_rdata.
  logic [16:0] exp_addr [3];
  logic        exp_we, exp_isp;
  logic [15:0] exp_wd;
  int          w_arr [3];
  logic [15:0] rd_arr [3];
  int          xfer_n = 0;
  bit          noise_en = 0;
  logic [31:0] m_ram = '0;
  logic [15:0] m_drd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus slave: acks each transfer after w_arr[xfer] wait cycles; a wait of
  // TO or more never gets acked in time and forces a timeout.
  initial begin : slave
    bit in_xfer;
    int wleft;
    in_xfer = 0;
    wleft = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        if (!in_xfer) begin
          in_xfer = 1;
          wleft = w_arr[xfer_n];
        end
        check("bus_addr", 32'(mem_addr_o), 32'(exp_addr[xfer_n]));
        check("bus_ispace", 32'(mem_ispace_o), 32'(exp_isp));
        check("bus_we", 32'(mem_we_o), 32'(exp_we));
        if (exp_we) check("bus_wdata", 32'(mem_wdata_o), 32'(exp_wd));
        if (wleft == 0) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = rd_arr[xfer_n];
          in_xfer = 0;
          if (xfer_n < 2) xfer_n++;
        end else begin
          wleft--;
        end
      end else begin
        in_xfer = 0;
        if (noise_en) begin
          mem_ack_i = 1'($urandom_range(0, 1));
          mem_rdata_i = 16'($urandom);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
      check("idle_req", 32'(mem_req_o), 32'd0);
      check("idle_rdy", 32'({ram_data_ready_o, d_ready_o, bus_err_o}), 32'd0);
      check("idle_busy", 32'(ram_busy_o), 32'd0);
      check("idle_ram_data", ram_data_o, m_ram);
      check("idle_d_rdata", 32'(d_rdata_o), 32'(m_drd));
    end
  endtask

  task automatic do_fetch(input logic [15:0] a, input int w0, input int w1,
                          input logic [15:0] d0, input logic [15:0] d1);
    int cyc, n_exp;
    bit to;
    exp_addr[0] = {a, 1'b0};
    exp_addr[1] = {a, 1'b1};
    exp_we = 1'b0;
    exp_isp = 1'b1;
    w_arr[0] = w0;
    w_arr[1] = w1;
    rd_arr[0] = d0;
    rd_arr[1] = d1;
    xfer_n = 0;
    ram_read_i = 1'b1;
    ram_addr_i = a;
    cyc = 0;
    do begin
      @(posedge clk_i);
      #1;
      cyc++;
    end while (!ram_cack_o && cyc < 8);
    check("fetch_cack_lat", cyc, 1);
    check("fetch_no_dcack", 32'(d_cack_o), 32'd0);
    ram_read_i = 1'b0;
    ram_addr_i = 16'($urandom);
    if (w0 >= TO) begin
      to = 1;
      n_exp = TO;
    end else begin
      to = (w1 >= TO);
      n_exp = w0 + 1 + ((w1 + 1 < TO) ? w1 + 1 : TO);
    end
    m_ram = to ? 32'h0 : {d1, d0};
    cyc = 0;
    while (!ram_data_ready_o && cyc < 600) begin
      check("fetch_busy", 32'(ram_busy_o), 32'd1);
      @(posedge clk_i);
      #1;
      cyc++;
      if (!ram_data_ready_o) check("fetch_cack_pulse", 32'(ram_cack_o), 32'd0);
    end
    check("fetch_lat", cyc, n_exp);
    check("fetch_data", ram_data_o, m_ram);
    check("fetch_bus_err", 32'(bus_err_o), 32'(to));
    check("fetch_req_done", 32'(mem_req_o), 32'd0);
    check("fetch_d_rdata", 32'(d_rdata_o), 32'(m_drd));
  endtask

  task automatic do_data(input logic we, input logic [15:0] a, input logic [15:0] wd,
                         input int w, input logic [15:0] rd);
    int cyc, n_exp;
    bit to;
    exp_addr[0] = {1'b0, a};
    exp_we = we;
    exp_isp = 1'b0;
    exp_wd = wd;
    w_arr[0] = w;
    rd_arr[0] = rd;
    xfer_n = 0;
    d_req_i = 1'b1;
    d_we_i = we;
    d_addr_i = a;
    d_wdata_i = wd;
    cyc = 0;
    do begin
      @(posedge clk_i);
      #1;
      cyc++;
    end while (!d_cack_o && cyc < 8);
    check("data_cack_lat", cyc, 1);
    check("data_no_rcack", 32'(ram_cack_o), 32'd0);
    d_req_i = 1'b0;
    d_we_i = 1'($urandom);
    d_addr_i = 16'($urandom);
    d_wdata_i = 16'($urandom);
    to = (w >= TO);
    n_exp = (w + 1 < TO) ? w + 1 : TO;
    if (!we) m_drd = to ? 16'h0 : rd;
    cyc = 0;
    while (!d_ready_o && cyc < 600) begin
      check("data_busy", 32'(ram_busy_o), 32'd1);
      @(posedge clk_i);
      #1;
      cyc++;
      check("data_no_rcack_wait", 32'(ram_cack_o), 32'd0);
    end
    check("data_lat", cyc, n_exp);
    check("data_rdata", 32'(d_rdata_o), 32'(m_drd));
    check("data_bus_err", 32'(bus_err_o), 32'(to));
    check("data_req_done", 32'(mem_req_o), 32'd0);
    check("data_ram_data", ram_data_o, m_ram);
  endtask

  initial begin : main
    logic [15:0] a;
    int op;
    rst_ni = 1'b0;
    ram_read_i = 1'b0;
    ram_addr_i = '0;
    d_req_i = 1'b0;
    d_we_i = 1'b0;
    d_addr_i = '0;
    d_wdata_i = '0;
    w_arr[0] = 0; w_arr[1] = 0; w_arr[2] = 0;
    rd_arr[0] = '0; rd_arr[1] = '0; rd_arr[2] = '0;
    exp_addr[0] = '0; exp_addr[1] = '0; exp_addr[2] = '0;
    exp_we = 1'b0; exp_isp = 1'b0; exp_wd = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_outs", 32'({ram_cack_o, ram_data_ready_o, ram_busy_o, d_cack_o, d_ready_o,
                           mem_req_o, mem_we_o, mem_ispace_o, bus_err_o}), 32'd0);
    check("rst_ram_data", ram_data_o, 32'h0);
    check("rst_d_rdata", 32'(d_rdata_o), 32'h0);
    check("rst_mem_addr", 32'(mem_addr_o), 32'h0);
    rst_ni = 1'b1;
    idle(2);

    do_fetch(16'h0012, 0, 0, 16'hBEEF, 16'h1234);
    check("fetch_0012_data", ram_data_o, 32'h1234BEEF);
    idle(1);
    do_data(1'b1, 16'h0100, 16'hA5A5, 2, 16'h0000);
    idle(1);
    do_data(1'b0, 16'h0100, 16'h0000, 2, 16'hA5A5);
    check("read_a5a5", 32'(d_rdata_o), 32'h0000A5A5);
    idle(1);

    ram_read_i = 1'b1;
    ram_addr_i = 16'h0040;
    do_data(1'b0, 16'h2222, 16'h0, 0, 16'h5A5A);
    do_fetch(16'h0040, 1, 0, 16'h1111, 16'h2222);
    idle(1);

    do_fetch(16'h0777, 200, 0, 16'hDEAD, 16'hDEAD);
    check("timeout_data_zero", ram_data_o, 32'h0);
    idle(1);
    do_fetch(16'h0778, 0, TO - 1, 16'h3333, 16'h4444);
    idle(1);
    do_data(1'b0, 16'h0005, 16'h0, TO, 16'h7777);
    idle(1);
    do_fetch(16'hFFFF, 0, 1, 16'hCAFE, 16'hF00D);
    idle(1);

    // Reset asserted mid-cycle while the high half of a fetch is pending.
    exp_addr[0] = {16'h0300, 1'b0};
    exp_addr[1] = {16'h0300, 1'b1};
    exp_we = 1'b0;
    exp_isp = 1'b1;
    w_arr[0] = 0;
    w_arr[1] = 50;
    rd_arr[0] = 16'h9999;
    rd_arr[1] = 16'h8888;
    xfer_n = 0;
    ram_read_i = 1'b1;
    ram_addr_i = 16'h0300;
    @(posedge clk_i);
    #1;
    check("rstmid_cack", 32'(ram_cack_o), 32'd1);
    ram_read_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("rstmid_hi_addr", 32'(mem_addr_o), 32'h00601);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rstmid_req_async", 32'(mem_req_o), 32'd0);
    repeat (2) begin
      @(posedge clk_i);
      #1;
      check("rstmid_no_ready", 32'(ram_data_ready_o), 32'd0);
    end
    rst_ni = 1'b1;
    m_ram = '0;
    m_drd = '0;
    idle(3);

    noise_en = 1;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      a = 16'($urandom);
      case (op)
        0: do_fetch(a, $urandom_range(0, TO), $urandom_range(0, TO),
                    16'($urandom), 16'($urandom));
        1: do_data(1'b1, a, 16'($urandom), $urandom_range(0, TO), 16'($urandom));
        2: do_data(1'b0, a, 16'($urandom), $urandom_range(0, TO), 16'($urandom));
        default: begin
          ram_read_i = 1'b1;
          ram_addr_i = a;
          do_data(1'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, TO),
                  16'($urandom));
          do_fetch(a, $urandom_range(0, TO), $urandom_range(0, TO),
                   16'($urandom), 16'($urandom));
        end
      endcase
      idle($urandom_range(1, 3));
    end
    noise_en = 0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
